// File: rtl/calc_pkg.sv
// Shared types and constants for the parametrised button calculator.
package calc_pkg;

  typedef enum logic [1:0] {
    ENTER_A  = 2'd0,
    ENTER_B  = 2'd1,
    SHOW_RES = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_AND = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_S,
    ACT_L,
    ACT_R,
    ACT_U,
    ACT_D
  } act_e;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    hex7 = 7'h7F;
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      4'hF: hex7 = 7'h0E;
      default: hex7 = 7'h7F;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter; emits a one-cycle pulse on
// each accepted rising level of a raw push button.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic press
);

  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             r_sync0;
  logic             r_sync1;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;
  logic             w_settle;

  // The level flips on the DB_CYCLES-th consecutive sample that disagrees with it.
  assign w_settle = (r_sync1 != r_level) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync0 <= btn_in;
      r_sync1 <= r_sync0;
      r_press <= 1'b0;
      if (r_sync1 == r_level) begin
        r_cnt <= '0;
      end else if (w_settle) begin
        r_cnt   <= '0;
        r_level <= r_sync1;
        r_press <= r_sync1;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign press = r_press;

endmodule

// File: rtl/calculator_param.sv
// Button-driven hex calculator: operand entry FSM, W-bit ALU with overflow,
// and a multiplexed active-low seven-segment display.
module calculator_param
  import calc_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned DB_CYCLES   = 1000000,
  parameter int unsigned SCAN_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btnU,
  input  logic              btnD,
  input  logic              btnL,
  input  logic              btnR,
  input  logic              btnS,
  input  logic [1:0]        sw,
  output logic [DIGITS-1:0] an,
  output logic [7:0]        seg,
  output logic              overflow
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned W2   = 2 * W;
  localparam int unsigned CW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned SCW  = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [CW-1:0]  CUR_MAX   = CW'(DIGITS - 1);
  localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_CYCLES - 1);

  logic w_pu, w_pd, w_pl, w_pr, w_ps;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_u (.clk(clk), .rst_n(rst_n), .btn_in(btnU), .press(w_pu));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_d (.clk(clk), .rst_n(rst_n), .btn_in(btnD), .press(w_pd));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_l (.clk(clk), .rst_n(rst_n), .btn_in(btnL), .press(w_pl));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_r (.clk(clk), .rst_n(rst_n), .btn_in(btnR), .press(w_pr));
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_s (.clk(clk), .rst_n(rst_n), .btn_in(btnS), .press(w_ps));

  state_e           r_state;
  state_e           w_state_nx;
  logic [W-1:0]     r_a, r_b, r_r;
  logic [W-1:0]     w_a_nx, w_b_nx, w_r_nx;
  logic [CW-1:0]    r_cursor, w_cur_nx;
  logic             r_ovf, w_ovf_nx;
  logic [CW-1:0]    r_scan_idx;
  logic [SCW-1:0]   r_scan_cnt;
  logic [DIGITS-1:0] r_an;
  logic [7:0]       r_seg;

  act_e             w_act;
  logic [W-1:0]     w_edit;
  logic [3:0]       w_nib;
  logic [CW+1:0]    w_base;
  logic [W:0]       w_sum;
  logic [W2-1:0]    w_prod;
  logic [W-1:0]     w_res;
  logic             w_res_ovf;

  // Only the highest-priority pulse of a cycle is acted on.
  always_comb begin
    w_act = ACT_NONE;
    if (w_ps)      w_act = ACT_S;
    else if (w_pl) w_act = ACT_L;
    else if (w_pr) w_act = ACT_R;
    else if (w_pu) w_act = ACT_U;
    else if (w_pd) w_act = ACT_D;
  end

  always_comb begin
    w_sum     = {1'b0, r_a} + {1'b0, r_b};
    w_prod    = W2'(r_a) * W2'(r_b);
    w_res     = '0;
    w_res_ovf = 1'b0;
    case (op_e'(sw))
      OP_ADD: begin
        w_res     = w_sum[W-1:0];
        w_res_ovf = w_sum[W];
      end
      OP_SUB: begin
        w_res     = r_a - r_b;
        w_res_ovf = (r_a < r_b);
      end
      OP_MUL: begin
        w_res     = w_prod[W-1:0];
        w_res_ovf = |w_prod[W2-1:W];
      end
      OP_AND: begin
        w_res     = r_a & r_b;
        w_res_ovf = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    w_a_nx     = r_a;
    w_b_nx     = r_b;
    w_r_nx     = r_r;
    w_cur_nx   = r_cursor;
    w_ovf_nx   = r_ovf;
    w_base     = {r_cursor, 2'b00};
    w_edit     = (r_state == ENTER_B) ? r_b : r_a;
    w_nib      = w_edit[w_base +: 4];
    case (w_act)
      ACT_U:   w_nib = w_nib + 4'd1;
      ACT_D:   w_nib = w_nib - 4'd1;
      default: ;
    endcase
    w_edit[w_base +: 4] = w_nib;

    case (r_state)
      ENTER_A, ENTER_B: begin
        if (r_state == ENTER_A) w_a_nx = w_edit;
        else                    w_b_nx = w_edit;
        case (w_act)
          ACT_L: w_cur_nx = (r_cursor == CUR_MAX) ? '0 : r_cursor + CW'(1);
          ACT_R: w_cur_nx = (r_cursor == '0) ? CUR_MAX : r_cursor - CW'(1);
          ACT_S: begin
            w_cur_nx = '0;
            if (r_state == ENTER_A) begin
              w_state_nx = ENTER_B;
              w_b_nx     = '0;
            end else begin
              w_state_nx = SHOW_RES;
              w_r_nx     = w_res;
              w_ovf_nx   = w_res_ovf;
            end
          end
          default: ;
        endcase
      end
      SHOW_RES: begin
        if (w_act == ACT_S) begin
          w_state_nx = ENTER_A;
          w_a_nx     = r_r;
          w_cur_nx   = '0;
        end
      end
      default: w_state_nx = ENTER_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ENTER_A;
    else        r_state <= w_state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_r      <= '0;
      r_cursor <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_a      <= w_a_nx;
      r_b      <= w_b_nx;
      r_r      <= w_r_nx;
      r_cursor <= w_cur_nx;
      r_ovf    <= w_ovf_nx;
    end
  end

  logic [W-1:0] w_disp_val;
  logic [3:0]   w_disp_nib;
  logic         w_dp_lit;

  always_comb begin
    w_disp_val = (r_state == SHOW_RES) ? r_r : ((r_state == ENTER_B) ? r_b : r_a);
    w_disp_nib = w_disp_val[{r_scan_idx, 2'b00} +: 4];
    if (r_state == SHOW_RES) w_dp_lit = r_ovf && (r_scan_idx == CUR_MAX);
    else                     w_dp_lit = (r_scan_idx == r_cursor);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_scan_idx <= '0;
      r_an       <= '1;
      r_seg      <= SEG_OFF;
    end else begin
      if (r_scan_cnt == SCAN_LAST) begin
        r_scan_cnt <= '0;
        r_scan_idx <= (r_scan_idx == CUR_MAX) ? '0 : r_scan_idx + CW'(1);
      end else begin
        r_scan_cnt <= r_scan_cnt + SCW'(1);
      end
      r_an  <= ~(DIGITS'(1) << r_scan_idx);
      r_seg <= {~w_dp_lit, hex7(w_disp_nib)};
    end
  end

  assign an       = r_an;
  assign seg      = r_seg;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_calculator_param.sv
// Randomised and directed bench for calculator_param against a behavioural
// model of the operand-entry calculator, observed through the scanned display.
module tb_calculator_param;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned DB     = 4;
  localparam int unsigned SCAN   = 8;
  localparam int unsigned W      = 4 * DIGITS;
  localparam longint unsigned MASK = (64'd1 << W) - 64'd1;

  localparam int B_S = 1, B_L = 2, B_R = 4, B_U = 8, B_D = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              btnU = 1'b0, btnD = 1'b0, btnL = 1'b0, btnR = 1'b0, btnS = 1'b0;
  logic [1:0]        sw = 2'b00;
  logic [DIGITS-1:0] an;
  logic [7:0]        seg;
  logic              overflow;

  int n_checks = 0;
  int n_errors = 0;

  calculator_param #(
    .DIGITS(DIGITS),
    .DB_CYCLES(DB),
    .SCAN_CYCLES(SCAN)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR), .btnS(btnS),
    .sw(sw), .an(an), .seg(seg), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int              m_state;
  longint unsigned m_a, m_b, m_r;
  int              m_cur;
  bit              m_ovf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Lit segments {g..a}, active-high, for hex digits 0-F.
  function automatic logic [6:0] lit_of(input int n);
    logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[n];
  endfunction

  function automatic longint unsigned bump(longint unsigned v, int c, int d);
    longint unsigned nib;
    nib = ((v >> (4 * c)) + longint'(d)) & 64'hF;
    return (v & ~(64'hF << (4 * c))) | (nib << (4 * c));
  endfunction

  task automatic model_reset();
    m_state = 0; m_a = 0; m_b = 0; m_r = 0; m_cur = 0; m_ovf = 0;
  endtask

  task automatic model_apply(input int mask);
    int act;
    longint unsigned t;
    act = 0;
    for (int i = 4; i >= 0; i--) if (mask[i]) act = 1 << i;
    if (m_state == 2) begin
      if (act == B_S) begin m_state = 0; m_a = m_r; m_cur = 0; end
    end else begin
      case (act)
        B_U: if (m_state == 0) m_a = bump(m_a, m_cur, 1);  else m_b = bump(m_b, m_cur, 1);
        B_D: if (m_state == 0) m_a = bump(m_a, m_cur, 15); else m_b = bump(m_b, m_cur, 15);
        B_L: m_cur = (m_cur + 1) % DIGITS;
        B_R: m_cur = (m_cur + DIGITS - 1) % DIGITS;
        B_S: begin
          m_cur = 0;
          if (m_state == 0) begin m_state = 1; m_b = 0; end
          else begin
            m_state = 2;
            case (sw)
              2'b00: begin t = m_a + m_b; m_r = t & MASK; m_ovf = (t > MASK); end
              2'b01: begin m_r = (m_a - m_b) & MASK; m_ovf = (m_a < m_b); end
              2'b10: begin t = m_a * m_b; m_r = t & MASK; m_ovf = (t > MASK); end
              default: begin m_r = m_a & m_b; m_ovf = 0; end
            endcase
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic drive_btns(input int mask);
    btnS = mask[0]; btnL = mask[1]; btnR = mask[2]; btnU = mask[3]; btnD = mask[4];
  endtask

  task automatic press(input int mask);
    @(negedge clk);
    drive_btns(mask);
    repeat (DB + 6) @(negedge clk);
    drive_btns(0);
    repeat (DB + 6) @(negedge clk);
    model_apply(mask);
  endtask

  task automatic read_display(output logic [63:0] val, output logic [DIGITS-1:0] dp);
    val = '0;
    dp  = '0;
    for (int d = 0; d < DIGITS; d++) begin
      int budget;
      int nib;
      logic [DIGITS-1:0] want;
      budget = 4 * DIGITS * SCAN;
      want   = ~(DIGITS'(1) << d);
      while (an !== want && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (an !== want) check("scan_enable", 64'(an), 64'(want));
      nib = -1;
      for (int n = 0; n < 16; n++) if (seg[6:0] === ~lit_of(n)) nib = n;
      if (nib < 0) val[4*d +: 4] = 4'hx;
      else         val[4*d +: 4] = 4'(nib);
      dp[d] = ~seg[7];
    end
  endtask

  task automatic check_display(input string tag);
    logic [63:0]       val;
    logic [DIGITS-1:0] dp;
    longint unsigned   exp_val;
    logic [DIGITS-1:0] exp_dp;
    read_display(val, dp);
    exp_val = (m_state == 0) ? m_a : ((m_state == 1) ? m_b : m_r);
    if (m_state == 2) exp_dp = m_ovf ? (DIGITS'(1) << (DIGITS - 1)) : '0;
    else              exp_dp = DIGITS'(1) << m_cur;
    check({tag, "_val"}, val, exp_val);
    check({tag, "_dp"}, 64'(dp), 64'(exp_dp));
    check({tag, "_ovf"}, 64'(overflow), 64'(m_ovf));
  endtask

  task automatic step(input int mask, input string tag);
    press(mask);
    check_display(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_btns(0);
    rst_n = 1'b0;
    #1;
    check("rst_an", 64'(an), 64'({DIGITS{1'b1}}));
    check("rst_seg", 64'(seg), 64'hFF);
    check("rst_ovf", 64'(overflow), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check("rel_an", 64'(an), 64'({DIGITS{1'b1}} ^ 1));
    check("rel_seg", 64'(seg), 64'h40);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0]       v;
    logic [DIGITS-1:0] d;
    int                m;

    do_reset();
    check_display("reset");

    sw = 2'b00;
    step(B_U, "add_a"); step(B_U, "add_a"); step(B_L, "add_a"); step(B_U, "add_a");
    check("add_A_const", m_a, 64'h0012);
    step(B_S, "add_b");
    step(B_U, "add_b"); step(B_U, "add_b"); step(B_U, "add_b");
    step(B_S, "add_res");
    read_display(v, d);
    check("add_R_const", v, 64'h0015);
    check("add_ovf_const", 64'(overflow), 64'd0);
    step(B_S, "chain");
    read_display(v, d);
    check("chain_A_const", v, 64'h0015);

    do_reset();
    sw = 2'b01;
    step(B_U, "sub"); step(B_S, "sub"); step(B_U, "sub"); step(B_U, "sub");
    step(B_S, "sub_res");
    read_display(v, d);
    check("sub_R_const", v, 64'hFFFF);
    check("sub_dp_msd", 64'(d), 64'h8);
    check("sub_ovf_const", 64'(overflow), 64'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_an", 64'(an), 64'({DIGITS{1'b1}}));
    check("async_seg", 64'(seg), 64'hFF);
    check("async_ovf", 64'(overflow), 64'd0);

    do_reset();
    sw = 2'b10;
    step(B_L, "mul"); step(B_L, "mul"); step(B_U, "mul"); step(B_S, "mul");
    step(B_L, "mul"); step(B_L, "mul"); step(B_U, "mul"); step(B_S, "mul_res");
    read_display(v, d);
    check("mul_R_const", v, 64'h0000);
    check("mul_ovf_const", 64'(overflow), 64'd1);

    do_reset();
    step(B_R, "wrap_r");
    read_display(v, d);
    check("wrap_cursor", 64'(d), 64'h8);
    step(B_D, "wrap"); step(B_R, "wrap"); step(B_U, "wrap"); step(B_L, "wrap");
    step(B_U, "nib_wrap");
    check("nib_wrap_const", m_a, 64'h0100);
    step(B_S | B_U, "prio");
    read_display(v, d);
    check("prio_B_const", v, 64'h0000);
    @(negedge clk);
    btnU = 1'b1;
    repeat (2) @(negedge clk);
    btnU = 1'b0;
    repeat (3 * DB + 6) @(negedge clk);
    check_display("glitch");

    do_reset();
    for (int i = 0; i < 60; i++) begin
      sw = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0)
        m = (1 << $urandom_range(0, 4)) | (1 << $urandom_range(0, 4));
      else
        m = 1 << $urandom_range(0, 4);
      step(m, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
